// File: rtl/simon_key_schedule_ctrl.sv
// Simon 32/64 key-schedule sequencer: feeds an external 2-stage round-key generator,
// captures each new round key into a 32x16 store and flags when the schedule is complete.
`timescale 1ns/1ps
module simon_key_schedule_ctrl #(
  parameter int NUM_ROUNDS = 32,
  parameter int KEY_WORDS  = 4,
  parameter int GEN_LAT    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [63:0] key,
  output logic [15:0] gen_k1,
  output logic [15:0] gen_k3,
  output logic [15:0] gen_km,
  output logic [4:0]  gen_z_idx,
  input  logic [15:0] gen_subkey,
  output logic        busy,
  output logic        done,
  output logic        keys_valid,
  input  logic [4:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic [2:0]  state_dbg
);

  // Handshake: a key transfers on any rising edge where key_valid && key_ready;
  // key_valid while key_ready is low is ignored and key is not sampled.

  typedef enum logic [2:0] {IDLE, ISSUE, HOLD, CAPT, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  round;
  logic [1:0]  wait_cnt;
  logic [15:0] store [NUM_ROUNDS];
  logic        accept;
  logic        last_round;
  logic        hold_done;

  assign accept     = key_valid && key_ready;
  assign last_round = (round == 5'(NUM_ROUNDS - 1));
  assign hold_done  = (wait_cnt == 2'(GEN_LAT - 2));

  assign key_ready = (state_q == IDLE);
  assign busy      = (state_q == ISSUE) || (state_q == HOLD) || (state_q == CAPT);
  assign done      = (state_q == DONE);
  assign rd_data   = store[rd_addr];
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (key_valid) state_d = ISSUE;
      ISSUE:   state_d = HOLD;
      HOLD:    if (hold_done) state_d = CAPT;
      CAPT:    state_d = last_round ? DONE : ISSUE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      round      <= 5'd0;
      wait_cnt   <= 2'd0;
      keys_valid <= 1'b0;
      gen_k1     <= 16'd0;
      gen_k3     <= 16'd0;
      gen_km     <= 16'd0;
      gen_z_idx  <= 5'd0;
    end else begin
      state_q <= state_d;
      if (state_q == ISSUE) wait_cnt <= 2'd0;
      else if (state_q == HOLD) wait_cnt <= wait_cnt + 2'd1;
      if (accept) begin
        round      <= 5'(KEY_WORDS);
        keys_valid <= 1'b0;
        gen_k1     <= key[63:48];
        gen_k3     <= key[31:16];
        gen_km     <= key[15:0];
        gen_z_idx  <= 5'd0;
      end else if (state_q == CAPT) begin
        if (last_round) begin
          keys_valid <= 1'b1;
        end else begin
          // The key being captured this edge is k[i-1] of the next round: forward it.
          round     <= round + 5'd1;
          gen_k1    <= gen_subkey;
          gen_k3    <= store[round - 5'(KEY_WORDS - 2)];
          gen_km    <= store[round - 5'(KEY_WORDS - 1)];
          gen_z_idx <= round - 5'(KEY_WORDS - 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      store[0] <= key[15:0];
      store[1] <= key[31:16];
      store[2] <= key[47:32];
      store[3] <= key[63:48];
    end else if (state_q == CAPT) begin
      store[round] <= gen_subkey;
    end
  end

endmodule
